// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_pkg
//  Description : Shared constants and FSM state encoding for the SNN image
//                loader and its storage.
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

   // Image bytes per frame and valid image bits per frame (28x28)
   localparam int NUM_BYTES  = 98;
   localparam int IMG_BITS   = 784;

   // Geometry of the byte-wide frame store
   localparam int RAM_DATA_W = 8;
   localparam int RAM_ADDR_W = 7;

   // Loader sequencing states
   typedef enum logic [2:0] {
      ST_LOAD      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_CORE = 3'd2,
      ST_SEND      = 3'd3,
      ST_WAIT_TX   = 3'd4
   } state_t;

endpackage : snn_pkg
`default_nettype wire

// File: rtl/ram.sv
`default_nettype none
// ============================================================================
//  Module      : ram
//  Description : Simple dual-port RAM, one synchronous write port and one
//                registered read port. A read of the address being written
//                in the same cycle returns the previous contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

   // Write and read on the same edge; non-blocking update gives read-old-data
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata <= mem_q[raddr];
   end

endmodule : ram
`default_nettype wire

// File: rtl/snn_image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : snn_image_loader
//  Description : Collects one image frame from a byte stream into a frame
//                store, launches the SNN core, serves single-bit reads to the
//                core with one cycle of latency, and forwards the classified
//                digit to a byte transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_image_loader
   import snn_pkg::*;
#(
   parameter int NUM_BYTES = snn_pkg::NUM_BYTES,
   parameter int IMG_BITS  = snn_pkg::IMG_BITS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_rdy,
   input  logic [9:0] addr_input_unit,
   output logic       q_input,
   output logic       start,
   input  logic       done,
   input  logic [3:0] digit,
   output logic [7:0] tx_data,
   output logic       trmt,
   input  logic       tx_done,
   output logic       busy
);

   localparam logic [6:0]  C_LAST_SLOT = 7'(NUM_BYTES - 1);
   localparam logic [10:0] C_IMG_LIMIT = 11'(IMG_BITS);

   state_t     state_q,    state_d;
   logic [6:0] byte_cnt_q, byte_cnt_d;
   logic [7:0] tx_data_q,  tx_data_d;
   logic [2:0] bit_sel_q,  bit_sel_d;
   logic       in_range_q, in_range_d;

   logic       w_wr_en;
   logic [7:0] w_ram_rdata;

   // Frame store: written at the running byte count, read by byte address
   ram #(
      .DATA_WIDTH (RAM_DATA_W),
      .ADDR_WIDTH (RAM_ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (w_wr_en),
      .waddr (byte_cnt_q),
      .wdata (rx_data),
      .raddr (addr_input_unit[9:3]),
      .rdata (w_ram_rdata)
   );

   // Sequencer: load bytes, pulse start, await core, pulse trmt, await tx
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      tx_data_d  = tx_data_q;
      w_wr_en    = 1'b0;
      start      = 1'b0;
      trmt       = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (rx_rdy) begin
               w_wr_en = 1'b1;
               if (byte_cnt_q == C_LAST_SLOT) begin
                  byte_cnt_d = '0;
                  state_d    = ST_START;
               end else begin
                  byte_cnt_d = byte_cnt_q + 7'd1;
               end
            end
         end
         ST_START: begin
            start   = 1'b1;
            state_d = ST_WAIT_CORE;
         end
         ST_WAIT_CORE: begin
            if (done) begin
               tx_data_d = {4'h0, digit};
               state_d   = ST_SEND;
            end
         end
         ST_SEND: begin
            trmt    = 1'b1;
            state_d = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (tx_done) begin
               state_d = ST_LOAD;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   // Read side: the bit lane and range flag travel alongside the RAM read
   always_comb begin
      bit_sel_d  = addr_input_unit[2:0];
      in_range_d = ({1'b0, addr_input_unit} < C_IMG_LIMIT);
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_LOAD;
         byte_cnt_q <= '0;
         tx_data_q  <= '0;
         bit_sel_q  <= '0;
         in_range_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         tx_data_q  <= tx_data_d;
         bit_sel_q  <= bit_sel_d;
         in_range_q <= in_range_d;
      end
   end

   // Out-of-range addresses and the post-reset cycle read as zero
   assign q_input = in_range_q & w_ram_rdata[bit_sel_q];
   assign tx_data = tx_data_q;
   assign busy    = (state_q != ST_LOAD);

endmodule : snn_image_loader
`default_nettype wire

// File: tb/tb_snn_image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snn_image_loader
//  Description : Self-checking bench for snn_image_loader. A byte-array image
//                model predicts every bit read back; control pulses are
//                counted and compared against the expected protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_snn_image_loader;

   localparam int NB = 98;
   localparam int IB = 784;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_rdy;
   logic [9:0] addr_input_unit;
   logic       q_input;
   logic       start;
   logic       done;
   logic [3:0] digit;
   logic [7:0] tx_data;
   logic       trmt;
   logic       tx_done;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int start_cnt = 0;
   int trmt_cnt  = 0;

   // Reference image and loader acceptance model
   logic [7:0] img [0:NB-1];
   bit         m_loading;
   int         m_cnt;

   always #5 clk = ~clk;

   snn_image_loader #(
      .NUM_BYTES (NB),
      .IMG_BITS  (IB)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .rx_data         (rx_data),
      .rx_rdy          (rx_rdy),
      .addr_input_unit (addr_input_unit),
      .q_input         (q_input),
      .start           (start),
      .done            (done),
      .digit           (digit),
      .tx_data         (tx_data),
      .trmt            (trmt),
      .tx_done         (tx_done),
      .busy            (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and sample just after the edge
   task automatic step();
      @(posedge clk);
      #1;
      if (start === 1'b1) start_cnt++;
      if (trmt === 1'b1)  trmt_cnt++;
   endtask

   function automatic logic ref_bit(input int a);
      if (a >= IB) return 1'b0;
      return img[a / 8][a % 8];
   endfunction

   // Optional idle gap, then a one-cycle rx_rdy pulse
   task automatic send_byte(input logic [7:0] b, input int max_gap);
      repeat ($urandom_range(max_gap, 0)) step();
      rx_data = b;
      rx_rdy  = 1'b1;
      step();
      rx_rdy  = 1'b0;
      rx_data = 8'($urandom);
      if (m_loading) begin
         img[m_cnt] = b;
         m_cnt++;
         if (m_cnt == NB) begin
            m_cnt     = 0;
            m_loading = 1'b0;
         end
      end
   endtask

   // Back-to-back reads, one address per cycle
   task automatic read_addrs(input string tag, input int addrs[$]);
      foreach (addrs[i]) begin
         addr_input_unit = 10'(addrs[i]);
         step();
         check(tag, 32'(q_input), 32'(ref_bit(addrs[i])));
      end
   endtask

   initial begin
      int aq[$];
      int s0;
      int t0;

      rst = 1'b1; rx_data = '0; rx_rdy = 1'b0; addr_input_unit = '0;
      done = 1'b0; digit = '0; tx_done = 1'b0;
      m_loading = 1'b1; m_cnt = 0;
      repeat (3) step();
      rst = 1'b0;
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_start",   32'(start),   32'd0);
      check("rst_trmt",    32'(trmt),    32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_q",       32'(q_input), 32'd0);

      // done while loading is ignored
      done = 1'b1; digit = 4'd5;
      step();
      done = 1'b0;
      step();
      check("load_done_tx", 32'(tx_data), 32'd0);
      check("load_done_trmt_cnt", 32'(trmt_cnt), 32'd0);
      check("load_done_busy", 32'(busy), 32'd0);

      // Frame 1: bytes 0x01..0x62
      for (int k = 0; k < NB - 1; k++) send_byte(8'(k + 1), 2);
      check("f1_no_early_start", 32'(start_cnt), 32'd0);
      send_byte(8'(NB), 2);
      check("f1_start", 32'(start), 32'd1);
      check("f1_start_cnt", 32'(start_cnt), 32'd1);
      check("f1_busy", 32'(busy), 32'd1);
      step();
      check("f1_start_end", 32'(start), 32'd0);

      addr_input_unit = 10'd0;
      step();
      check("f1_addr0", 32'(q_input), 32'd1);
      addr_input_unit = 10'd8;
      #2;
      check("f1_latency_hold", 32'(q_input), 32'd1);
      step();
      check("f1_addr8", 32'(q_input), 32'd0);
      addr_input_unit = 10'd9;
      step();
      check("f1_addr9", 32'(q_input), 32'd1);
      aq.delete();
      for (int i = 0; i < 64; i++) aq.push_back(int'($urandom_range(1023, 0)));
      read_addrs("f1_rand_rd", aq);

      // Stray rx_rdy and tx_done while waiting for the core
      for (int i = 0; i < 6; i++) begin
         rx_data = 8'($urandom);
         rx_rdy  = 1'b1;
         step();
         rx_rdy  = 1'b0;
         step();
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check("wc_busy", 32'(busy), 32'd1);
      check("wc_trmt_cnt", 32'(trmt_cnt), 32'd0);
      aq.delete();
      for (int i = 0; i < 64; i++) aq.push_back(int'($urandom_range(IB - 1, 0)));
      read_addrs("wc_reread", aq);

      // Core result
      digit = 4'd7; done = 1'b1;
      step();
      done = 1'b0; digit = 4'd0;
      check("send_trmt", 32'(trmt), 32'd1);
      check("send_tx_data", 32'(tx_data), 32'h07);
      step();
      check("send_trmt_end", 32'(trmt), 32'd0);
      done = 1'b1; digit = 4'd3;
      step();
      done = 1'b0;
      check("wtx_done_ignored", 32'(tx_data), 32'h07);
      check("wtx_trmt_cnt", 32'(trmt_cnt), 32'd1);
      check("wtx_busy", 32'(busy), 32'd1);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check("tx_done_busy", 32'(busy), 32'd0);
      m_loading = 1'b1;

      // Partial frame lands from slot 0, then reset discards it
      for (int k = 0; k < 50; k++) send_byte(8'($urandom), 1);
      aq.delete();
      for (int i = 0; i < 32; i++) aq.push_back(int'($urandom_range(399, 0)));
      read_addrs("partial_rd", aq);
      rst = 1'b1;
      step();
      rst = 1'b0;
      m_loading = 1'b1; m_cnt = 0;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_tx_data", 32'(tx_data), 32'd0);
      s0 = start_cnt;
      for (int k = 0; k < NB - 1; k++) send_byte(8'hFF, 1);
      check("ff_no_early_start", 32'(start_cnt), 32'(s0));
      send_byte(8'hFF, 1);
      check("ff_start", 32'(start), 32'd1);
      aq.delete();
      for (int a = 0; a < IB; a++) aq.push_back(a);
      aq.push_back(784);
      aq.push_back(1023);
      read_addrs("ff_rd", aq);
      addr_input_unit = 10'd1023;
      step();
      check("ff_addr1023", 32'(q_input), 32'd0);

      // Reset while waiting for the core abandons the result
      t0 = trmt_cnt;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("wc_rst_busy", 32'(busy), 32'd0);
      done = 1'b1; digit = 4'd9;
      step();
      done = 1'b0;
      repeat (4) step();
      check("wc_rst_no_trmt", 32'(trmt_cnt), 32'(t0));
      check("wc_rst_tx_data", 32'(tx_data), 32'd0);
      m_loading = 1'b1; m_cnt = 0;

      // Random frame, full streaming read-back
      s0 = start_cnt;
      for (int k = 0; k < NB; k++) send_byte(8'($urandom), 1);
      check("rf_start", 32'(start), 32'd1);
      check("rf_start_cnt", 32'(start_cnt), 32'(s0 + 1));
      aq.delete();
      for (int a = 0; a < IB; a++) aq.push_back(a);
      for (int i = 0; i < 16; i++) aq.push_back(int'($urandom_range(1023, IB)));
      read_addrs("rf_stream", aq);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_snn_image_loader
`default_nettype wire
